alu_md_unit: RTL and testbench

ALU_MD_UNIT -- requirements
Module: alu_md_unit

---
 rtl/alu_md_pkg.sv | 117 +++++++++++
 rtl/alu_md_iter.sv | 123 ++++++++++++
 rtl/alu_md_unit.sv | 177 +++++++++++++++++
 tb/tb_alu_md_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_md_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alu_md_pkg
// Description : Shared encodings for the ALU / multiply-divide unit: alu_op
//               selector codes, funct3/funct7 field codes, FSM state
//               encoding, the internal operation enumeration and the
//               instruction-field decoder.
// Config      : ALU_MD_MEXT_EN (consumed by alu_md_unit; the decoder takes
//               the resulting enable as an argument)
// Revision    : 1.0 - initial release
// ============================================================================
package alu_md_pkg;

    // alu_op selector
    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;
    localparam logic [1:0] c_aluop_rsvd  = 2'b11;

    // Base integer funct3 codes
    localparam logic [2:0] c_f3_add_sub = 3'b000;
    localparam logic [2:0] c_f3_sll     = 3'b001;
    localparam logic [2:0] c_f3_slt     = 3'b010;
    localparam logic [2:0] c_f3_sltu    = 3'b011;
    localparam logic [2:0] c_f3_xor     = 3'b100;
    localparam logic [2:0] c_f3_srl_sra = 3'b101;
    localparam logic [2:0] c_f3_or      = 3'b110;
    localparam logic [2:0] c_f3_and     = 3'b111;

    // Multiply/divide funct3 codes
    localparam logic [2:0] c_f3_mul    = 3'b000;
    localparam logic [2:0] c_f3_mulh   = 3'b001;
    localparam logic [2:0] c_f3_mulhsu = 3'b010;
    localparam logic [2:0] c_f3_mulhu  = 3'b011;
    localparam logic [2:0] c_f3_div    = 3'b100;
    localparam logic [2:0] c_f3_divu   = 3'b101;
    localparam logic [2:0] c_f3_rem    = 3'b110;
    localparam logic [2:0] c_f3_remu   = 3'b111;

    // funct7 codes
    localparam logic [6:0] c_f7_base = 7'b0000000;
    localparam logic [6:0] c_f7_alt  = 7'b0100000;
    localparam logic [6:0] c_f7_mext = 7'b0000001;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t c_st_idle = 2'd0;
    localparam state_t c_st_busy = 2'd1;
    localparam state_t c_st_done = 2'd2;

    // Internal operation enumeration
    typedef enum logic [4:0] {
        c_op_add, c_op_sub, c_op_sll, c_op_slt, c_op_sltu, c_op_xor,
        c_op_srl, c_op_sra, c_op_or, c_op_and,
        c_op_mul, c_op_mulh, c_op_mulhsu, c_op_mulhu,
        c_op_div, c_op_divu, c_op_rem, c_op_remu,
        c_op_illegal
    } op_e;

    // Map instruction fields to an internal op. With mext_en low the
    // multiply/divide funct7 falls through to the unlisted-funct7 case.
    function automatic op_e decode_op(
        input logic [1:0] alu_op,
        input logic [2:0] funct3,
        input logic [6:0] funct7,
        input logic       opcode5,
        input logic       mext_en
    );
        op_e op;
        op = c_op_illegal;
        case (alu_op)
            c_aluop_add:  op = c_op_add;
            c_aluop_sub:  op = c_op_sub;
            c_aluop_rsvd: op = c_op_illegal;
            c_aluop_funct: begin
                if (opcode5 && (funct7 == c_f7_mext)) begin
                    if (mext_en) begin
                        case (funct3)
                            c_f3_mul:    op = c_op_mul;
                            c_f3_mulh:   op = c_op_mulh;
                            c_f3_mulhsu: op = c_op_mulhsu;
                            c_f3_mulhu:  op = c_op_mulhu;
                            c_f3_div:    op = c_op_div;
                            c_f3_divu:   op = c_op_divu;
                            c_f3_rem:    op = c_op_rem;
                            default:     op = c_op_remu;
                        endcase
                    end
                end else if (opcode5 && (funct7 != c_f7_base) && (funct7 != c_f7_alt)) begin
                    op = c_op_illegal;
                end else begin
                    case (funct3)
                        c_f3_add_sub: begin
                            // Only R-type distinguishes sub; I-type immediates reuse funct7 bits
                            if (opcode5 && funct7[5]) op = c_op_sub;
                            else                      op = c_op_add;
                        end
                        c_f3_sll:  op = c_op_sll;
                        c_f3_slt:  op = c_op_slt;
                        c_f3_sltu: op = c_op_sltu;
                        c_f3_xor:  op = c_op_xor;
                        c_f3_srl_sra: begin
                            if (funct7[5]) op = c_op_sra;
                            else           op = c_op_srl;
                        end
                        c_f3_or:   op = c_op_or;
                        default:   op = c_op_and;
                    endcase
                end
            end
            default: op = c_op_illegal;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_md_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_md_iter
// Description : Iterative radix-2 multiply/divide engine. Operands are
//               converted to magnitudes on start, a shift-add multiplier or
//               restoring divider runs for exactly XLEN cycles, and the
//               sign fix-up is applied combinationally on the final step.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               start         - load operands and begin (one-cycle pulse)
//               op            - multiply/divide operation to run
//               src_a, src_b  - operands (XLEN)
//               done          - high during the last iteration cycle
//               result        - final result, valid while done is high
// Config      : instantiated only when ALU_MD_MEXT_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
module alu_md_iter
    import alu_md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  op_e             op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int             CW         = $clog2(XLEN);
    localparam logic [CW-1:0]  c_cnt_last = CW'(XLEN - 1);

    logic            r_busy;
    logic [CW-1:0]   r_cnt;
    op_e             r_op;
    logic [XLEN-1:0] r_hi;      // product high / partial remainder
    logic [XLEN-1:0] r_lo;      // multiplier / dividend, becomes low product / quotient
    logic [XLEN-1:0] r_opnd;    // multiplicand / divisor magnitude
    logic            r_neg_q;   // negate product or quotient
    logic            r_neg_r;   // negate remainder (follows dividend sign)

    logic            w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag;
    logic            w_is_div;
    logic [XLEN:0]   w_add, w_shl, w_diff;
    logic            w_qbit;
    logic [XLEN-1:0] w_hi_nxt, w_lo_nxt;
    logic [2*XLEN-1:0] w_prod, w_prod_fix;

    // Operand magnitude conversion at start
    always_comb begin
        w_a_neg = src_a[XLEN-1] && ((op == c_op_mulh) || (op == c_op_mulhsu) ||
                                    (op == c_op_div)  || (op == c_op_rem));
        w_b_neg = src_b[XLEN-1] && ((op == c_op_mulh) || (op == c_op_div) ||
                                    (op == c_op_rem));
        w_a_mag = w_a_neg ? -src_a : src_a;
        w_b_mag = w_b_neg ? -src_b : src_b;
    end

    // One radix-2 step for either algorithm
    always_comb begin
        w_is_div = (r_op == c_op_div) || (r_op == c_op_divu) ||
                   (r_op == c_op_rem) || (r_op == c_op_remu);
        w_add    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
        w_shl    = {r_hi, r_lo[XLEN-1]};
        w_diff   = w_shl - {1'b0, r_opnd};
        w_qbit   = ~w_diff[XLEN];
        if (w_is_div) begin
            w_hi_nxt = w_qbit ? w_diff[XLEN-1:0] : w_shl[XLEN-1:0];
            w_lo_nxt = {r_lo[XLEN-2:0], w_qbit};
        end else begin
            w_hi_nxt = w_add[XLEN:1];
            w_lo_nxt = {w_add[0], r_lo[XLEN-1:1]};
        end
    end

    // Sign fix-up applied to the post-step values so the result is ready on done
    always_comb begin
        w_prod     = {w_hi_nxt, w_lo_nxt};
        w_prod_fix = r_neg_q ? -w_prod : w_prod;
        result     = '0;
        case (r_op)
            c_op_mul:                            result = w_prod_fix[XLEN-1:0];
            c_op_mulh, c_op_mulhsu, c_op_mulhu:  result = w_prod_fix[2*XLEN-1:XLEN];
            c_op_div, c_op_divu:                 result = r_neg_q ? -w_lo_nxt : w_lo_nxt;
            c_op_rem, c_op_remu:                 result = r_neg_r ? -w_hi_nxt : w_hi_nxt;
            default:                             result = '0;
        endcase
    end

    assign done = r_busy && (r_cnt == c_cnt_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_op    <= c_op_mul;
            r_hi    <= '0;
            r_lo    <= '0;
            r_opnd  <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (start) begin
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_op    <= op;
            r_hi    <= '0;
            r_lo    <= w_a_mag;
            r_opnd  <= w_b_mag;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
        end else if (r_busy) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (done) r_busy <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_md_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_md_unit
// Description : Integer ALU with optional iterative multiply/divide,
//               valid/ready handshakes on request and result. Single-cycle
//               ops complete one cycle after accept; multiply/divide runs
//               XLEN cycles in BUSY. Division specials bypass BUSY.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               in_valid / in_ready    - request handshake
//               alu_op, funct3, funct7, opcode5 - operation select
//               src_a, src_b           - operands (XLEN)
//               out_valid / out_ready  - result handshake
//               result, zero, illegal  - held stable in DONE
// Config      : ALU_MD_MEXT_EN - enables multiply/divide (alu_md_iter)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_md_unit
    import alu_md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            opcode5,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

`ifdef ALU_MD_MEXT_EN
    localparam logic c_mext_en = 1'b1;
`else
    localparam logic c_mext_en = 1'b0;
`endif
    localparam int c_shw = $clog2(XLEN);

    state_t          r_state, w_state_nxt;
    logic [XLEN-1:0] r_result, w_result_nxt;
    logic            r_zero, w_zero_nxt;
    logic            r_illegal, w_illegal_nxt;

    op_e             w_op;
    logic [c_shw-1:0] w_shamt;
    logic [XLEN-1:0] w_fast;
    logic            w_mop_iter;     // accepted op must go through BUSY
    logic            w_iter_done;
    logic [XLEN-1:0] w_iter_result;

    assign w_op    = decode_op(alu_op, funct3, funct7, opcode5, c_mext_en);
    assign w_shamt = src_b[c_shw-1:0];

`ifdef ALU_MD_MEXT_EN
    localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};

    logic            w_is_mop, w_is_div, w_b_zero, w_ovf, w_iter_start;
    logic [XLEN-1:0] w_special;

    assign w_is_mop = (w_op == c_op_mul)  || (w_op == c_op_mulh) || (w_op == c_op_mulhsu) ||
                      (w_op == c_op_mulhu) || w_is_div;
    assign w_is_div = (w_op == c_op_div) || (w_op == c_op_divu) ||
                      (w_op == c_op_rem) || (w_op == c_op_remu);
    assign w_b_zero = (src_b == '0);
    assign w_ovf    = ((w_op == c_op_div) || (w_op == c_op_rem)) &&
                      (src_a == c_int_min) && (src_b == '1);

    // Divide-by-zero and signed overflow have closed-form answers
    assign w_special = ((w_op == c_op_div) || (w_op == c_op_divu))
                     ? (w_b_zero ? '1 : src_a)
                     : (w_b_zero ? src_a : '0);

    assign w_mop_iter   = w_is_mop && !(w_is_div && (w_b_zero || w_ovf));
    assign w_iter_start = (r_state == c_st_idle) && in_valid && w_mop_iter;

    alu_md_iter #(
        .XLEN   (XLEN)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (w_iter_start),
        .op     (w_op),
        .src_a  (src_a),
        .src_b  (src_b),
        .done   (w_iter_done),
        .result (w_iter_result)
    );
`else
    assign w_mop_iter    = 1'b0;
    assign w_iter_done   = 1'b0;
    assign w_iter_result = '0;
`endif

    // Single-cycle datapath
    always_comb begin
        w_fast = '0;
        case (w_op)
            c_op_add:  w_fast = src_a + src_b;
            c_op_sub:  w_fast = src_a - src_b;
            c_op_sll:  w_fast = src_a << w_shamt;
            c_op_slt:  w_fast = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            c_op_sltu: w_fast = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            c_op_xor:  w_fast = src_a ^ src_b;
            c_op_srl:  w_fast = src_a >> w_shamt;
            c_op_sra:  w_fast = $signed(src_a) >>> w_shamt;
            c_op_or:   w_fast = src_a | src_b;
            c_op_and:  w_fast = src_a & src_b;
`ifdef ALU_MD_MEXT_EN
            c_op_div, c_op_divu, c_op_rem, c_op_remu: w_fast = w_special;
`endif
            default:   w_fast = '0;
        endcase
    end

    // Next-state and result capture
    always_comb begin
        w_state_nxt   = r_state;
        w_result_nxt  = r_result;
        w_zero_nxt    = r_zero;
        w_illegal_nxt = r_illegal;
        case (r_state)
            c_st_idle: begin
                if (in_valid) begin
                    if (w_mop_iter) begin
                        w_state_nxt = c_st_busy;
                    end else begin
                        w_state_nxt   = c_st_done;
                        w_result_nxt  = w_fast;
                        w_zero_nxt    = (w_fast == '0);
                        w_illegal_nxt = (w_op == c_op_illegal);
                    end
                end
            end
            c_st_busy: begin
                if (w_iter_done) begin
                    w_state_nxt   = c_st_done;
                    w_result_nxt  = w_iter_result;
                    w_zero_nxt    = (w_iter_result == '0);
                    w_illegal_nxt = 1'b0;
                end
            end
            c_st_done: begin
                if (out_ready) w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_result  <= w_result_nxt;
            r_zero    <= w_zero_nxt;
            r_illegal <= w_illegal_nxt;
        end
    end

    assign in_ready  = (r_state == c_st_idle);
    assign out_valid = (r_state == c_st_done);
    assign result    = r_result;
    assign zero      = r_zero;
    assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_md_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_md_unit
// Description : Directed and randomized self-checking bench for alu_md_unit
//               (XLEN=32). Expected results are queued at issue and popped
//               when out_valid appears.
// Config      : ALU_MD_MEXT_EN - selects multiply/divide expectations
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_md_unit;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, opcode5, out_valid, out_ready, zero, illegal;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] src_a, src_b, result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    alu_md_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .opcode5(opcode5),
        .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        src_a   = $urandom;
        src_b   = $urandom;
        alu_op  = 2'($urandom);
        funct3  = 3'($urandom);
        funct7  = 7'($urandom);
        opcode5 = 1'($urandom);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".in_ready"},  in_ready,  1);
        chk({tag, ".out_valid"}, out_valid, 0);
        chk({tag, ".result"},    result,    0);
        chk({tag, ".zero"},      zero,      0);
        chk({tag, ".illegal"},   illegal,   0);
    endtask

    // Issue one request, await its result, compare, then optionally hold
    // out_ready low for 'hold' cycles while checking stability.
    task automatic run_op(input string tag, input logic [1:0] aop, input logic [2:0] f3,
                          input logic [6:0] f7, input logic op5, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eres, input logic eill,
                          input int elat, input int hold, input logic early);
        exp_t e, got;
        int   lat;
        e.res = eres; e.zero = (eres == 32'd0); e.ill = eill; e.lat = elat;
        sb_q.push_back(e);
        lat = 0;
        while (in_ready !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
        chk({tag, ".ready"}, in_ready, 1);
        alu_op = aop; funct3 = f3; funct7 = f7; opcode5 = op5;
        src_a = a; src_b = b; in_valid = 1'b1; out_ready = early;
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
        got = sb_q.pop_front();
        chk({tag, ".valid"},   out_valid, 1);
        chk({tag, ".result"},  result,    got.res);
        chk({tag, ".zero"},    zero,      got.zero);
        chk({tag, ".illegal"}, illegal,   got.ill);
        chk({tag, ".latency"}, lat,       got.lat);
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            scramble();
            @(posedge clk); #1;
            chk({tag, ".hold_result"},   result,    got.res);
            chk({tag, ".hold_zero"},     zero,      got.zero);
            chk({tag, ".hold_in_ready"}, in_ready,  0);
            chk({tag, ".hold_valid"},    out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".idle"}, in_ready, 1);
    endtask

    function automatic logic [31:0] ref_base(input logic [2:0] f3, input logic alt,
                                             input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        sa = a;
        case (f3)
            3'd0:    return alt ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return {31'd0, ($signed(a) < $signed(b))};
            3'd3:    return {31'd0, (a < b)};
            3'd4:    return a ^ b;
            3'd5:    return alt ? 32'(sa >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0]        ua, ub, up;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin up = ua * ub; return up[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * $signed(ub); return sp[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return a;
                sp = sa / sb; return sp[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'd0;
                sp = sa % sb; return sp[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    initial begin
        logic [31:0] a, b, e;
        logic [2:0]  f3;
        logic        alt;
        int          lat;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = 2'd0; funct3 = 3'd0; funct7 = 7'd0; opcode5 = 1'b0;
        src_a = 32'd0; src_b = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset_state("reset");

        // Directed single-cycle operations
        run_op("add",      2'b00, 3'd0, 7'h00, 1'b0, 32'd5, 32'd7, 32'd12, 1'b0, 1, 0, 1'b0);
        run_op("sub_zero", 2'b01, 3'd0, 7'h00, 1'b0, 32'd5, 32'd5, 32'd0,  1'b0, 1, 0, 1'b0);
        run_op("sra",      2'b10, 3'd5, 7'h20, 1'b1, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1, 0, 1'b0);
        run_op("srl",      2'b10, 3'd5, 7'h00, 1'b1, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1, 0, 1'b0);
        run_op("sltu",     2'b10, 3'd3, 7'h00, 1'b1, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1, 0, 1'b0);
        run_op("slt",      2'b10, 3'd2, 7'h00, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1, 0, 1'b0);
        run_op("rsub",     2'b10, 3'd0, 7'h20, 1'b1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1, 0, 1'b0);
        run_op("iadd",     2'b10, 3'd0, 7'h20, 1'b0, 32'd3, 32'd5, 32'd8, 1'b0, 1, 0, 1'b0);
        run_op("sll_mask", 2'b10, 3'd1, 7'h00, 1'b1, 32'd1, 32'h21, 32'd2, 1'b0, 1, 0, 1'b1);
        run_op("rsvd",     2'b11, 3'd0, 7'h00, 1'b0, 32'd5, 32'd7, 32'd0, 1'b1, 1, 0, 1'b0);
        run_op("bad_f7",   2'b10, 3'd0, 7'h02, 1'b1, 32'd5, 32'd7, 32'd0, 1'b1, 1, 0, 1'b0);

        // Randomized base operations against the reference model
        for (int i = 0; i < 8; i++) begin
            a = $urandom; b = $urandom; f3 = 3'(i); alt = 1'($urandom);
            e = ref_base(f3, alt, a, b);
            run_op("rnd_base", 2'b10, f3, alt ? 7'h20 : 7'h00, 1'b1, a, b, e, 1'b0, 1, 0, 1'b0);
        end

        // Hold result in DONE with out_ready low while inputs toggle
        run_op("hold_xor", 2'b10, 3'd4, 7'h00, 1'b1, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1'b0, 1, 5, 1'b0);

`ifdef ALU_MD_MEXT_EN
        run_op("mulhu",    2'b10, 3'd3, 7'h01, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33, 0, 1'b0);
        run_op("mulh",     2'b10, 3'd1, 7'h01, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 0, 1'b1);
        run_op("mul_neg",  2'b10, 3'd0, 7'h01, 1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33, 0, 1'b0);
        run_op("mulhsu",   2'b10, 3'd2, 7'h01, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, 33, 0, 1'b0);
        run_op("div_neg",  2'b10, 3'd4, 7'h01, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33, 0, 1'b0);
        run_op("rem_neg",  2'b10, 3'd6, 7'h01, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33, 0, 1'b0);
        run_op("divu",     2'b10, 3'd5, 7'h01, 1'b1, 32'd100, 32'd7, 32'd14, 1'b0, 33, 0, 1'b0);
        run_op("remu",     2'b10, 3'd7, 7'h01, 1'b1, 32'd100, 32'd7, 32'd2, 1'b0, 33, 2, 1'b0);
        run_op("div0",     2'b10, 3'd4, 7'h01, 1'b1, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b0, 1, 0, 1'b0);
        run_op("rem0",     2'b10, 3'd6, 7'h01, 1'b1, 32'd100, 32'd0, 32'd100, 1'b0, 1, 0, 1'b0);
        run_op("divu0",    2'b10, 3'd5, 7'h01, 1'b1, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b0, 1, 0, 1'b0);
        run_op("div_ovf",  2'b10, 3'd4, 7'h01, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1, 0, 1'b0);
        run_op("rem_ovf",  2'b10, 3'd6, 7'h01, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1, 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            a = $urandom; b = $urandom >> (i * 3); f3 = 3'(i);
            e = ref_m(f3, a, b);
            lat = (f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
            run_op("rnd_m", 2'b10, f3, 7'h01, 1'b1, a, b, e, 1'b0, lat, 0, 1'b0);
        end
`else
        run_op("mul_noext", 2'b10, 3'd0, 7'h01, 1'b1, 32'd6, 32'd7, 32'd0, 1'b1, 1, 0, 1'b0);
        run_op("div_noext", 2'b10, 3'd4, 7'h01, 1'b1, 32'd100, 32'd0, 32'd0, 1'b1, 1, 0, 1'b0);
`endif

        // Reset while holding a result in DONE
        alu_op = 2'b00; src_a = 32'd5; src_b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst_done.pre_valid", out_valid, 1);
        chk("rst_done.pre_result", result, 32'd12);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_state("rst_done");

`ifdef ALU_MD_MEXT_EN
        // Reset in the middle of an iterative operation
        run_op("pre_busy", 2'b00, 3'd0, 7'h00, 1'b0, 32'd1, 32'd1, 32'd2, 1'b0, 1, 0, 1'b0);
        alu_op = 2'b10; funct3 = 3'd3; funct7 = 7'h01; opcode5 = 1'b1;
        src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_busy.pre_ready", in_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_state("rst_busy");
        run_op("post_rst_mul", 2'b10, 3'd0, 7'h01, 1'b1, 32'd6, 32'd7, 32'd42, 1'b0, 33, 0, 1'b0);
`endif

        // Reserved alu_op after all other traffic
        run_op("rsvd2", 2'b11, 3'd7, 7'h01, 1'b1, 32'hFFFF_FFFF, 32'd3, 32'd0, 1'b1, 1, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
